// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a single-line, write-back,
// write-allocate cache. Takes one CPU word request at a time, looks it up,
// on a miss writes back a dirty victim and refills the block from memory,
// then re-looks-up and completes. Keeps saturating hit/miss/writeback
// counters.
module cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  // CPU side
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic [31:0]        cpu_rdata,
  // cache array side
  output logic [ADDR_W-1:0]  cache_addr,
  output logic               cache_we_block,
  output logic               cache_we_word,
  output logic [31:0]        cache_wdata_word,
  output logic [BLOCK_W-1:0] cache_wdata_block,
  input  logic               cache_hit,
  input  logic               cache_dirty,
  input  logic [ADDR_W-1:0]  cache_addout,
  input  logic [BLOCK_W-1:0] cache_rdata_block,
  input  logic [31:0]        cache_rdata_word,
  // memory side
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [BLOCK_W-1:0] mem_rdata,
  // performance counters
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   wb_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int TAG_LSB  = 6;
  localparam int NCNT     = 3;
  localparam int CNT_HIT  = 0;
  localparam int CNT_MISS = 1;
  localparam int CNT_WB   = 2;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              accept;

  logic [NCNT-1:0]             cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_q;

  assign accept = (state == S_IDLE) && cpu_req;

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (cache_hit)        state_nxt = S_RESP;
        else if (cache_dirty) state_nxt = S_WB;
        else                  state_nxt = S_REFILL;
      end
      S_WB:     if (mem_ack) state_nxt = S_REFILL;
      S_REFILL: if (mem_ack) state_nxt = S_LOOKUP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // state register; async reset abandons any in-flight memory transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // request latch: captured only on accept, held for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cpu_addr;
      we_q    <= cpu_we;
      wdata_q <= cpu_wdata;
    end
  end

  // CPU handshake: done/rdata are decoded from RESPOND, the cache word read
  // was launched during the preceding LOOKUP
  assign cpu_ready = (state == S_IDLE);
  assign cpu_done  = (state == S_RESP);
  assign cpu_rdata = ((state == S_RESP) && !we_q) ? cache_rdata_word : 32'h0;

  // cache strobes; a write miss lands its word on the post-refill re-lookup
  assign cache_addr        = addr_q;
  assign cache_we_word     = (state == S_LOOKUP) && cache_hit && we_q;
  assign cache_wdata_word  = wdata_q;
  assign cache_we_block    = (state == S_REFILL) && mem_ack;
  assign cache_wdata_block = mem_rdata;

  // memory request decode from state
  assign mem_req   = (state == S_WB) || (state == S_REFILL);
  assign mem_we    = (state == S_WB);
  assign mem_wdata = (state == S_WB) ? cache_rdata_block : '0;

  // memory address: victim base on writeback, aligned request block on refill
  always_comb begin
    mem_addr = '0;
    case (state)
      S_WB:     mem_addr = cache_addout;
      S_REFILL: mem_addr = {addr_q[ADDR_W-1:TAG_LSB], {TAG_LSB{1'b0}}};
      default:  mem_addr = '0;
    endcase
  end

  assign cnt_inc[CNT_HIT]  = (state == S_LOOKUP) && cache_hit;
  assign cnt_inc[CNT_MISS] = (state == S_LOOKUP) && !cache_hit;
  assign cnt_inc[CNT_WB]   = (state == S_WB) && mem_ack;

  // saturating performance counters, one per event
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        cnt_q[g] <= '0;
      else if (cnt_inc[g] && (cnt_q[g] != {CNT_W{1'b1}}))
        cnt_q[g] <= cnt_q[g] + CNT_W'(1);
    end
  end

  assign hit_cnt  = cnt_q[CNT_HIT];
  assign miss_cnt = cnt_q[CNT_MISS];
  assign wb_cnt   = cnt_q[CNT_WB];

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: drives cache_ctrl with a behavioural single-line cache and a
// latency-programmable memory, and checks CPU-visible results, latencies and
// counters against a flat-memory reference model.
module tb_cache_ctrl;
  localparam int ADDR_W = 32;
  localparam int BLOCK_W = 512;
  localparam int CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 0, rst = 0;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic [31:0] cache_addr;
  logic cache_we_block, cache_we_word;
  logic [31:0] cache_wdata_word;
  logic [511:0] cache_wdata_block;
  logic cache_hit, cache_dirty;
  logic [31:0] cache_addout;
  logic [511:0] cache_rdata_block;
  logic [31:0] cache_rdata_word;
  logic mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [511:0] mem_wdata;
  logic mem_ack = 0;
  logic [511:0] mem_rdata = '0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  int n_checks = 0, n_pass = 0;

  cache_ctrl #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_we_block(cache_we_block), .cache_we_word(cache_we_word),
    .cache_wdata_word(cache_wdata_word), .cache_wdata_block(cache_wdata_block),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_addout(cache_addout),
    .cache_rdata_block(cache_rdata_block), .cache_rdata_word(cache_rdata_word),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- single-line cache array (environment) ----------------
  logic c_valid = 0, c_dirty = 0;
  logic [25:0] c_tag = 0;
  logic [511:0] c_data = '0;
  logic [31:0] c_rword = 0;

  assign cache_hit = c_valid && (c_tag == cache_addr[31:6]);
  assign cache_dirty = c_valid && c_dirty;
  assign cache_addout = {c_tag, 6'b0};
  assign cache_rdata_block = c_data;
  assign cache_rdata_word = c_rword;

  // registered word read and block/word writes of the cache array
  always @(posedge clk) begin
    c_rword <= c_data[int'(cache_addr[5:2])*32 +: 32];
    if (cache_we_block) begin
      c_data <= cache_wdata_block; c_valid <= 1'b1; c_tag <= cache_addr[31:6]; c_dirty <= 1'b0;
    end else if (cache_we_word) begin
      c_data[int'(cache_addr[5:2])*32 +: 32] <= cache_wdata_word; c_dirty <= 1'b1;
    end
  end

  // ---------------- backing memory ----------------
  logic [511:0] bmem [logic [31:0]];
  typedef struct { logic we; logic [31:0] addr; logic [511:0] wdata; } mlog_t;
  mlog_t mem_log[$];
  int fixed_delay = -1;
  bit force_ack = 0;
  int waits_total = 0;

  function automatic logic [31:0] pattern(input logic [31:0] w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [511:0] get_block(input logic [31:0] ba);
    logic [511:0] b;
    if (bmem.exists(ba)) return bmem[ba];
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = pattern((ba >> 2) + i);
    return b;
  endfunction

  // memory responder: acks each request after d wait cycles
  initial begin
    bit in_txn; int req_cycles; int d_cur; bit ack_now; mlog_t e;
    in_txn = 0; req_cycles = 0; d_cur = 0;
    forever begin
      @(negedge clk);
      ack_now = 1'b0;
      if (!rst) in_txn = 1'b0;
      else if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; req_cycles = 0;
          d_cur = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (req_cycles == d_cur) begin
          ack_now = 1'b1; in_txn = 1'b0; waits_total += d_cur;
          e.we = mem_we; e.addr = mem_addr; e.wdata = mem_wdata;
          mem_log.push_back(e);
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = get_block(mem_addr);
        end else req_cycles++;
      end
      mem_ack = ack_now | force_ack;
    end
  end

  // ---------------- reference model: flat memory + abstract line ----------------
  logic [31:0] ref_mem [logic [31:0]];
  bit r_valid = 0, r_dirty = 0;
  logic [25:0] r_tag = 0;
  int r_hit = 0, r_miss = 0, r_wb = 0;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : pattern(w);
  endfunction

  // base latency: 2 for hit, 4 clean miss, 5 dirty miss (memory waits extra)
  task automatic ref_apply(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           output int base, output logic [31:0] er);
    if (r_valid && r_tag == a[31:6]) begin
      r_hit = sat(r_hit); base = 2;
    end else begin
      r_miss = sat(r_miss);
      base = (r_valid && r_dirty) ? 5 : 4;
      if (r_valid && r_dirty) r_wb = sat(r_wb);
      r_hit = sat(r_hit);
      r_valid = 1; r_tag = a[31:6]; r_dirty = 0;
    end
    if (we) begin ref_mem[a >> 2] = wd; r_dirty = 1; er = 0; end
    else er = ref_word(a);
  endtask

  task automatic mem_preload(input logic [31:0] a, input logic [31:0] d);
    logic [511:0] b;
    b = get_block({a[31:6], 6'b0});
    b[int'(a[5:2])*32 +: 32] = d;
    bmem[{a[31:6], 6'b0}] = b;
    ref_mem[a >> 2] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0; cpu_req = 0;
    r_hit = 0; r_miss = 0; r_wb = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // issue one request and observe it to completion (no checking here)
  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output int nww,
                        output int nmreq, output bit to, output bit done_after, output int waits);
    int w0;
    @(negedge clk);
    w0 = waits_total;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0; nww = 0; nmreq = 0; to = 0; rd = 0;
    @(negedge clk);
    cpu_req = 0;
    lat = 1;
    forever begin
      if (cache_we_word) nww++;
      if (mem_req) nmreq++;
      if (cpu_done) break;
      if (lat > 300) begin to = 1; break; end
      @(negedge clk); lat++;
    end
    rd = cpu_rdata;
    @(negedge clk);
    done_after = cpu_done;
    waits = waits_total - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cpu_ready); else n_pass++;
    n_checks++; if ({cpu_done, mem_req, cache_we_word, cache_we_block} !== 4'b0) $display("FAIL reset_strobes got %b exp 0000", {cpu_done, mem_req, cache_we_word, cache_we_block}); else n_pass++;
    n_checks++; if (cache_addr !== 32'h0 || cpu_rdata !== 32'h0) $display("FAIL reset_addr_rdata got %h/%h exp 0/0", cache_addr, cpu_rdata); else n_pass++;
    n_checks++; if ({hit_cnt, miss_cnt, wb_cnt} !== '0) $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", hit_cnt, miss_cnt, wb_cnt); else n_pass++;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_refill_read();
    int lat, nww, nmr, w, base; bit to, da; logic [31:0] rd, er;
    mem_preload(32'h44, 32'hDEAD_BEEF);
    fixed_delay = 3; mem_log.delete();
    ref_apply(0, 32'h40, 0, base, er);
    do_req(0, 32'h40, 0, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (to || lat !== 7) $display("FAIL refill_lat got %0d exp 7 (timeout %0d)", lat, to); else n_pass++;
    n_checks++; if (mem_log.size() !== 1 || mem_log[0].addr !== 32'h40 || mem_log[0].we !== 1'b0) $display("FAIL refill_mem got n=%0d exp one read of 0x40", mem_log.size()); else n_pass++;
    n_checks++; if (rd !== er) $display("FAIL refill_rdata got %h exp %h", rd, er); else n_pass++;
    n_checks++; if (da !== 1'b0) $display("FAIL refill_done_width got %b exp 0", da); else n_pass++;
    fixed_delay = -1;
    ref_apply(0, 32'h44, 0, base, er);
    do_req(0, 32'h44, 0, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL read44 got %h exp deadbeef", rd); else n_pass++;
    n_checks++; if (miss_cnt !== 8'd1 || hit_cnt !== 8'd2) $display("FAIL refill_cnts got m%0d h%0d exp m1 h2", miss_cnt, hit_cnt); else n_pass++;
  endtask

  task automatic test_write_hit();
    int lat, nww, nmr, w, base; bit to, da; logic [31:0] rd, er;
    ref_apply(1, 32'h48, 32'h1234_5678, base, er);
    do_req(1, 32'h48, 32'h1234_5678, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (lat !== 2) $display("FAIL wr_hit_lat got %0d exp 2", lat); else n_pass++;
    n_checks++; if (nww !== 1) $display("FAIL wr_hit_we_word got %0d pulses exp 1", nww); else n_pass++;
    n_checks++; if (nmr !== 0 || rd !== 32'h0) $display("FAIL wr_hit_memreq got %0d rdata %h exp 0/0", nmr, rd); else n_pass++;
    ref_apply(0, 32'h48, 0, base, er);
    do_req(0, 32'h48, 0, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (rd !== 32'h1234_5678 || nmr !== 0) $display("FAIL rd48 got %h memreq %0d exp 12345678/0", rd, nmr); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    int lat, nww, nmr, w, base; bit to, da; logic [31:0] rd, er;
    mem_log.delete();
    ref_apply(0, 32'h1000_0000, 0, base, er);
    do_req(0, 32'h1000_0000, 0, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (mem_log.size() !== 2) $display("FAIL wb_ntxn got %0d exp 2", mem_log.size()); else n_pass++;
    if (mem_log.size() == 2) begin
      n_checks++; if (mem_log[0].we !== 1'b1 || mem_log[0].addr !== 32'h40) $display("FAIL wb_txn got we%b %h exp we1 00000040", mem_log[0].we, mem_log[0].addr); else n_pass++;
      n_checks++; if (mem_log[0].wdata[95:64] !== 32'h1234_5678) $display("FAIL wb_data got %h exp 12345678", mem_log[0].wdata[95:64]); else n_pass++;
      n_checks++; if (mem_log[1].we !== 1'b0 || mem_log[1].addr !== 32'h1000_0000) $display("FAIL wb_refill got we%b %h exp we0 10000000", mem_log[1].we, mem_log[1].addr); else n_pass++;
    end
    n_checks++; if (lat !== 5 + w) $display("FAIL wb_lat got %0d exp %0d", lat, 5 + w); else n_pass++;
    n_checks++; if (wb_cnt !== 8'd1 || rd !== er) $display("FAIL wb_cnt_rdata got %0d %h exp 1 %h", wb_cnt, rd, er); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, acc, bad, base1, base2, n; logic [31:0] er1, er2, a;
    a = 32'h2000_0080;
    fixed_delay = 10;
    ref_apply(0, a, 0, base1, er1);
    ref_apply(0, a, 0, base2, er2);
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = a; acc = cpu_ready ? 1 : 0; cyc = 0; bad = 0;
    forever begin
      @(negedge clk); cyc++;
      if (cpu_ready) acc++;
      if (cache_addr !== a) bad++;
      if (cpu_done || cyc > 100) break;
      cpu_addr = $urandom; cpu_we = 1'($urandom);
    end
    n_checks++; if (cpu_done !== 1'b1 || cpu_rdata !== er1 || cyc !== base1 + 10) $display("FAIL b2b_first got lat %0d rdata %h exp %0d %h", cyc, cpu_rdata, base1 + 10, er1); else n_pass++;
    n_checks++; if (acc !== 1 || bad !== 0) $display("FAIL b2b_accepts got %0d addr_changes %0d exp 1/0", acc, bad); else n_pass++;
    cpu_addr = a; cpu_we = 0;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL b2b_ready_after_done got %b exp 1", cpu_ready); else n_pass++;
    @(negedge clk);
    cpu_req = 0;
    n = 1;
    while (!cpu_done && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (cpu_done !== 1'b1 || n !== base2 || cpu_rdata !== er2) $display("FAIL b2b_second got lat %0d rdata %h exp %0d %h", n, cpu_rdata, base2, er2); else n_pass++;
    fixed_delay = -1;
  endtask

  task automatic test_reset_mid();
    int n, lat, nww, nmr, w, base; bit to, da; logic [31:0] rd, er;
    fixed_delay = 1000;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h3000_0000;
    @(negedge clk); cpu_req = 0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (!(mem_req === 1'b1 && mem_addr === 32'h3000_0000)) $display("FAIL rmid_refill got req %b addr %h exp 1 30000000", mem_req, mem_addr); else n_pass++;
    #3 rst = 0;
    r_hit = 0; r_miss = 0; r_wb = 0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1) $display("FAIL rmid_async got req %b ready %b exp 0/1", mem_req, cpu_ready); else n_pass++;
    n_checks++; if ({hit_cnt, miss_cnt, wb_cnt} !== '0 || cache_addr !== 32'h0) $display("FAIL rmid_clear got %0d/%0d/%0d addr %h exp 0", hit_cnt, miss_cnt, wb_cnt, cache_addr); else n_pass++;
    @(negedge clk); rst = 1; fixed_delay = -1;
    #2 force_ack = 1;
    @(negedge clk); #1;
    n_checks++; if (cache_we_block !== 1'b0 || mem_ack !== 1'b1) $display("FAIL rmid_late_ack got we_block %b ack %b exp 0/1", cache_we_block, mem_ack); else n_pass++;
    force_ack = 0;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || miss_cnt !== 8'd0) $display("FAIL rmid_idle got ready %b done %b miss %0d exp 1/0/0", cpu_ready, cpu_done, miss_cnt); else n_pass++;
    ref_apply(0, 32'h2000_0084, 0, base, er);
    do_req(0, 32'h2000_0084, 0, lat, rd, nww, nmr, to, da, w);
    n_checks++; if (rd !== er || lat !== base || hit_cnt !== 8'(r_hit)) $display("FAIL rmid_after got %h lat %0d hit %0d exp %h %0d %0d", rd, lat, hit_cnt, er, base, r_hit); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat, nww, nmr, w, base; bit to, da; logic [31:0] rd, er;
    for (int i = 0; i < CMAX + 5; i++) begin
      ref_apply(0, 32'h2000_0088, 0, base, er);
      do_req(0, 32'h2000_0088, 0, lat, rd, nww, nmr, to, da, w);
    end
    n_checks++; if (hit_cnt !== 8'hFF || r_hit !== CMAX) $display("FAIL sat_hit got %h exp ff", hit_cnt); else n_pass++;
    n_checks++; if (miss_cnt !== 8'(r_miss)) $display("FAIL sat_miss got %0d exp %0d", miss_cnt, r_miss); else n_pass++;
  endtask

  task automatic test_random();
    int lat, nww, nmr, w, base, errs; bit to, da, we; logic [31:0] rd, er, a, wd;
    logic [25:0] tags [4];
    tags[0] = 26'h1; tags[1] = 26'h2; tags[2] = 26'h40_0000; tags[3] = 26'h5;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
      wd = $urandom;
      ref_apply(we, a, wd, base, er);
      do_req(we, a, wd, lat, rd, nww, nmr, to, da, w);
      n_checks++;
      if (to || rd !== er || lat !== base + w || da !== 1'b0 ||
          hit_cnt !== 8'(r_hit) || miss_cnt !== 8'(r_miss) || wb_cnt !== 8'(r_wb)) begin
        if (errs < 10) $display("FAIL rand_%0d addr %h we %0d got rd %h lat %0d h%0d m%0d w%0d exp rd %h lat %0d h%0d m%0d w%0d",
          i, a, we, rd, lat, hit_cnt, miss_cnt, wb_cnt, er, base + w, r_hit, r_miss, r_wb);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_refill_read();
    test_write_hit();
    test_dirty_miss();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
